// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared LEGv8 writeback widths, XZR index and commit record
package pipe_pkg;

  localparam int PIPE_ADDR_W  = 5;
  localparam int PIPE_DATA_W  = 64;
  localparam int PIPE_STAMP_W = 16;
  localparam int XZR          = 31;

  typedef struct packed {
    logic [PIPE_ADDR_W-1:0]  addr;
    logic [PIPE_DATA_W-1:0]  data;
    logic [PIPE_STAMP_W-1:0] stamp;
  } wb_commit_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO
// Push while full is accepted only when a pop frees the head slot on the same edge.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Head is zeroed when empty so unwritten storage never leaks out.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - WB-stage commit trace FIFO with cycle stamps and drop accounting
module wb_trace_buffer
  import pipe_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = PIPE_ADDR_W,
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int STAMP_W  = PIPE_STAMP_W,
  parameter int ZERO_REG = XZR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_regwrite,
  input  logic [ADDR_W-1:0]      waddr_MEM_WB,
  input  logic [DATA_W-1:0]      wdata_WB,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic [STAMP_W-1:0]     out_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int ENTRY_W = ADDR_W + DATA_W + STAMP_W;

  logic [STAMP_W-1:0] r_stamp;
  logic               r_overflow;
  logic [15:0]        r_drop_count;
  logic               w_commit;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;

  assign w_commit = wb_regwrite && (waddr_MEM_WB != ADDR_W'(ZERO_REG));
  assign w_pop    = !w_empty && out_ready && !clear;
  assign w_push   = w_commit && !clear;
  // A full FIFO still takes the commit when the head leaves on the same edge.
  assign w_drop   = w_commit && w_full && !w_pop && !clear;

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (clear),
    .i_push  (w_push),
    .i_data  ({waddr_MEM_WB, wdata_WB, r_stamp}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign out_valid                       = !w_empty;
  assign {out_addr, out_data, out_stamp} = w_head;
  assign overflow                        = r_overflow;
  assign drop_count                      = r_drop_count;

  // The stamp keeps running through clear so stamps stay comparable across flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stamp <= '0;
    end else begin
      r_stamp <= r_stamp + STAMP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - self-checking bench for wb_trace_buffer
module tb_wb_trace_buffer;
  import pipe_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_regwrite;
  logic [4:0]  waddr_MEM_WB;
  logic [63:0] wdata_WB;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [63:0] out_data;
  logic [15:0] out_stamp;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_count;

  wb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_regwrite  (wb_regwrite),
    .waddr_MEM_WB (waddr_MEM_WB),
    .wdata_WB     (wdata_WB),
    .clear        (clear),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_stamp    (out_stamp),
    .count        (count),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  wb_commit_t  mq[$];
  logic        m_ovf;
  logic [15:0] m_drops;
  logic [15:0] m_stamp;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        rdy;
    logic        exp_valid;
    int          exp_count;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
    logic [15:0] exp_stamp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_drops = '0;
    m_stamp = '0;
  endtask

  task automatic model_check();
    chk("m_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_addr",  64'(out_addr),  (mq.size() != 0) ? 64'(mq[0].addr)  : 64'd0);
    chk("m_data",  out_data,       (mq.size() != 0) ? mq[0].data        : 64'd0);
    chk("m_stamp", 64'(out_stamp), (mq.size() != 0) ? 64'(mq[0].stamp) : 64'd0);
    chk("m_ovf",   64'(overflow), 64'(m_ovf));
    chk("m_drops", 64'(drop_count), 64'(m_drops));
  endtask

  // Model: clear wins; otherwise the head leaves first, then the commit fits or is dropped.
  task automatic model_step(input logic wr, input logic [4:0] a, input logic [63:0] d,
                            input logic rdy, input logic clr);
    if (clr) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = '0;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (wr && a != 5'(XZR)) begin
        if (mq.size() < DEPTH) begin
          mq.push_back('{addr: a, data: d, stamp: m_stamp});
        end else begin
          m_ovf = 1'b1;
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end
      end
    end
    m_stamp = m_stamp + 16'd1;
  endtask

  task automatic cycle(input logic wr, input logic [4:0] a, input logic [63:0] d,
                       input logic rdy, input logic clr);
    wb_regwrite  = wr;
    waddr_MEM_WB = a;
    wdata_WB     = d;
    out_ready    = rdy;
    clear        = clr;
    #1;
    model_check();
    model_step(wr, a, d, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];
  logic [15:0] held_stamp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; wb_regwrite = 1'b0; waddr_MEM_WB = '0; wdata_WB = '0;
    clear = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    chk("rst_addr",  64'(out_addr), 64'd0);
    chk("rst_data",  out_data, 64'd0);
    rst = 1'b1;
    model_reset();

    // In-order drain of three back-to-back commits, then an XZR write.
    vecs[0] = '{1'b1, 5'd1,  64'd5,      1'b1, 1'b0, 0, 5'd0, 64'd0,  16'd0};
    vecs[1] = '{1'b1, 5'd2,  64'd7,      1'b1, 1'b1, 1, 5'd1, 64'd5,  16'd0};
    vecs[2] = '{1'b1, 5'd3,  64'd12,     1'b1, 1'b1, 1, 5'd2, 64'd7,  16'd1};
    vecs[3] = '{1'b0, 5'd0,  64'd0,      1'b1, 1'b1, 1, 5'd3, 64'd12, 16'd2};
    vecs[4] = '{1'b1, 5'd31, 64'hDEAD,   1'b1, 1'b0, 0, 5'd0, 64'd0,  16'd0};
    vecs[5] = '{1'b0, 5'd0,  64'd0,      1'b1, 1'b0, 0, 5'd0, 64'd0,  16'd0};
    for (int i = 0; i < 6; i++) begin
      chk("tbl_valid", 64'(out_valid), 64'(vecs[i].exp_valid));
      chk("tbl_count", 64'(count), 64'(vecs[i].exp_count));
      chk("tbl_addr",  64'(out_addr), 64'(vecs[i].exp_addr));
      chk("tbl_data",  out_data, vecs[i].exp_data);
      chk("tbl_stamp", 64'(out_stamp), 64'(vecs[i].exp_stamp));
      chk("tbl_drops", 64'(drop_count), 64'd0);
      cycle(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rdy, 1'b0);
    end

    // Ten commits with no consumer: two are dropped.
    for (int i = 1; i <= 10; i++) cycle(1'b1, 5'(i), 64'h100 + 64'(i), 1'b0, 1'b0);
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_flag",  64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd2);
    chk("ovf_head",  64'(out_addr), 64'd1);

    // Full with commit and pop together: accepted, nothing dropped.
    cycle(1'b1, 5'd20, 64'h2000, 1'b1, 1'b0);
    chk("fpp_count", 64'(count), 64'd8);
    chk("fpp_drops", 64'(drop_count), 64'd2);
    for (int k = 0; k < 8; k++) begin
      chk("drain_addr", 64'(out_addr), (k < 7) ? 64'(k + 2) : 64'd20);
      chk("drain_data", out_data, (k < 7) ? 64'h100 + 64'(k + 2) : 64'h2000);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_ovf",   64'(overflow), 64'd1);

    // Head holds steady under back-pressure, then clear flushes everything.
    for (int i = 4; i <= 6; i++) cycle(1'b1, 5'(i), 64'hA0 + 64'(i), 1'b0, 1'b0);
    held_stamp = mq[0].stamp;
    for (int i = 0; i < 5; i++) begin
      chk("hold_addr",  64'(out_addr), 64'd4);
      chk("hold_data",  out_data, 64'hA4);
      chk("hold_stamp", 64'(out_stamp), 64'(held_stamp));
      cycle(1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    end
    cycle(1'b1, 5'd9, 64'h55, 1'b1, 1'b1);
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_ovf",   64'(overflow), 64'd0);
    chk("clr_drops", 64'(drop_count), 64'd0);

    // Asynchronous reset between edges with four entries held.
    for (int i = 7; i <= 10; i++) cycle(1'b1, 5'(i), 64'(i), 1'b0, 1'b0);
    wb_regwrite = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd4);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_addr",  64'(out_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    cycle(1'b1, 5'd9, 64'h99, 1'b0, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_addr",  64'(out_addr), 64'd9);
    chk("post_rst_stamp", 64'(out_stamp), 64'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 99) < 3));
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
    model_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Captures every architectural register write leaving the WB stage of the 5-stage LEGv8 pipeline (address, data, cycle stamp) into a FIFO.
- Provides a valid/ready read port so a checker or debug host can drain commits in program order.
- Counts commits dropped on overflow.
- Sits beside the pipeline top, tapping the same MEM/WB writeback signals that drive the register file write port.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2
- ADDR_W, 5, register address width
- DATA_W, 64, writeback data width
- STAMP_W, 16, cycle-stamp counter width
- ZERO_REG, 31, register index of XZR; writes to it are never captured

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- wb_regwrite  in  1  MEM/WB RegWrite control; qualifies a commit
- waddr_MEM_WB  in  ADDR_W  destination register of the commit
- wdata_WB  in  DATA_W  value written by the commit
- clear  in  1  synchronous flush of FIFO, drop counter and overflow flag
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry this cycle
- out_addr  out  ADDR_W  head entry register address
- out_data  out  DATA_W  head entry data
- out_stamp  out  STAMP_W  cycle stamp of head entry
- count  out  clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set on first dropped commit
- drop_count  out  16  dropped commits, saturating at 16'hFFFF

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, count=0, out_valid=0, overflow=0, drop_count=0, stamp counter=0. out_addr/out_data/out_stamp=0.
- Stamp counter: increments by 1 every clock, wraps at 2^STAMP_W-1 -> 0. An entry's stamp is the counter value in the cycle its commit is presented.
- Commit: wb_regwrite=1 and waddr_MEM_WB != ZERO_REG. Writes to ZERO_REG are ignored: no push, no drop.
- Push: commit and (count<DEPTH or pop this cycle). Entry written at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments mod DEPTH.
- Simultaneous push and pop: always accepted, including when full and when count=1; count unchanged.
- Full with no pop, commit present: commit dropped, overflow<=1, drop_count increments (saturating). FIFO contents are untouched.
- Read port is first-word fall-through:
  - out_valid = (count!=0).
  - out_* reflect the entry at rd_ptr combinationally from storage.
  - A push into an empty FIFO makes out_valid=1 on the next cycle (latency 1).
- out_* are stable while out_valid=1 and out_ready=0.
- clear=1: next edge sets pointers=0, count=0, overflow=0, drop_count=0. Any push or pop in that cycle is discarded. The stamp counter is not cleared.
- Reset asserted mid-operation discards all entries immediately. The first commit after release gets stamp counted from 0.
- No X propagation: wdata_WB is stored only on push.

Decomposition:
- Shared package pipe_pkg: ZERO_REG constant (XZR=31), ADDR_W/DATA_W widths, and a wb_commit_t struct {addr, data, stamp} reused by the pipeline top and checkers.
- One sub-module: sync_fifo_fwft (parameterised width/depth, push/pop/full/empty/count). wb_trace_buffer adds commit filtering, stamping, drop accounting and clear.

Test Plan:
- Reset then 3 commits (X1=5, X2=7, X3=12) on consecutive cycles, out_ready=1 -> out_valid rises 1 cycle after the first commit; entries emerge in order with stamps s, s+1, s+2; count returns to 0.
- Commit to X31 with data 64'hDEAD -> no entry, count stays 0, drop_count 0.
- out_ready=0, 10 commits with DEPTH=8 -> count=8, overflow=1, drop_count=2. Draining yields the first 8 commits unchanged.
- FIFO full, commit and pop in the same cycle -> count stays 8, drop_count unchanged, new entry appears last.
- Hold out_ready=0 for 5 cycles with out_valid=1 -> out_addr/out_data/out_stamp constant. Then clear=1 -> next cycle count=0, out_valid=0, overflow=0.
- Assert rst=0 asynchronously between edges with 4 entries held -> out_valid=0 and count=0 immediately, before the next clock edge.
